// File: rtl/rmii_rx_framer.sv
// RMII receive framer: samples CRS_DV/RXD dibits, strips preamble/SFD, emits
// LSB-first bytes on a valid/last/user stream with FCS, length and RXER checking.
module rmii_rx_framer #(
  parameter int unsigned MIN_FRAME_BYTES = 64,
  parameter int unsigned MAX_FRAME_BYTES = 1522
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        mode_speed,
  input  logic        rmii_crsdv,
  input  logic [1:0]  rmii_rxd,
  input  logic        rmii_rxer,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);

  localparam int unsigned CW          = $clog2(MAX_FRAME_BYTES + 2);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_FRAME, S_END, S_DROP} state_t;
  state_t state;

  logic          crsdv_r, rxer_r, speed_in_r, speed;
  logic [1:0]    rxd_r;
  logic          running;
  logic [3:0]    div;
  logic          samp;
  logic          low_prev;
  logic [1:0]    stash;
  logic [7:0]    shift, held;
  logic          held_v;
  logic [1:0]    idx;
  logic [CW-1:0] byte_count;
  logic [31:0]   crc;
  logic          rxer_seen;
  logic          frame_err;

  logic [7:0]    sh_n, cbyte;
  logic [1:0]    idx_n;
  logic          comp;
  logic [31:0]   crc_n;

  function automatic logic [7:0] put_dibit(input logic [7:0] b, input logic [1:0] i,
                                           input logic [1:0] d);
    logic [7:0] r;
    r = b;
    case (i)
      2'd0:    r[1:0] = d;
      2'd1:    r[3:2] = d;
      2'd2:    r[5:4] = d;
      default: r[7:6] = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int unsigned i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      crsdv_r    <= 1'b0;
      rxd_r      <= '0;
      rxer_r     <= 1'b0;
      speed_in_r <= 1'b0;
    end else begin
      crsdv_r    <= rmii_crsdv;
      rxd_r      <= rmii_rxd;
      rxer_r     <= rmii_rxer;
      speed_in_r <= mode_speed;
    end
  end

  assign samp      = speed | (running & (div == 4'd4));
  assign frame_err = (crc != CRC_RESIDUE) | rxer_seen | (idx != 2'd0) |
                     (byte_count < CW'(MIN_FRAME_BYTES));

  // A dibit seen with crsdv low is stashed: it is data only if carrier returns on
  // the next sample, in which case both the stashed and the current dibit land.
  always_comb begin
    sh_n  = shift;
    idx_n = idx;
    comp  = 1'b0;
    cbyte = shift;
    if (crsdv_r) begin
      if (low_prev) begin
        sh_n = put_dibit(sh_n, idx_n, stash);
        if (idx_n == 2'd3) begin
          comp  = 1'b1;
          cbyte = sh_n;
        end
        idx_n = idx_n + 2'd1;
      end
      sh_n = put_dibit(sh_n, idx_n, rxd_r);
      if (idx_n == 2'd3) begin
        comp  = 1'b1;
        cbyte = sh_n;
      end
      idx_n = idx_n + 2'd1;
    end
    crc_n = crc_byte(crc, cbyte);
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      speed      <= 1'b0;
      running    <= 1'b0;
      div        <= '0;
      low_prev   <= 1'b0;
      stash      <= '0;
      shift      <= '0;
      idx        <= '0;
      held       <= '0;
      held_v     <= 1'b0;
      byte_count <= '0;
      crc        <= '1;
      rxer_seen  <= 1'b0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      frame_cnt  <= '0;
      err_cnt    <= '0;
    end else begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
      if (state == S_IDLE) speed <= speed_in_r;
      // 10M sample phase: first sample 5 cycles after carrier is seen in IDLE
      if (running) div <= (div == 4'd9) ? '0 : div + 4'd1;
      else if (state == S_IDLE && crsdv_r) begin
        running <= 1'b1;
        div     <= '0;
      end

      case (state)
        S_IDLE: if (samp && crsdv_r) begin
          if (rxd_r == 2'b01) state <= S_PRE;
          else if (rxd_r == 2'b10) begin
            state    <= S_DROP;
            low_prev <= 1'b0;
          end
        end
        S_PRE: if (samp) begin
          if (!crsdv_r) begin
            state   <= S_IDLE;
            running <= 1'b0;
          end else if (rxd_r == 2'b11) begin
            state      <= S_FRAME;
            idx        <= '0;
            held_v     <= 1'b0;
            byte_count <= '0;
            crc        <= '1;
            rxer_seen  <= 1'b0;
            low_prev   <= 1'b0;
          end else if (rxd_r != 2'b01) begin
            state    <= S_DROP;
            low_prev <= 1'b0;
          end
        end
        S_FRAME: if (samp) begin
          if (rxer_r) rxer_seen <= 1'b1;
          if (!crsdv_r && low_prev) state <= S_END;
          else begin
            low_prev <= !crsdv_r;
            stash    <= rxd_r;
            shift    <= sh_n;
            idx      <= idx_n;
            if (comp) begin
              crc    <= crc_n;
              held   <= cbyte;
              held_v <= 1'b1;
              if (held_v) begin
                m_tdata  <= held;
                m_tvalid <= 1'b1;
              end
              if (byte_count == CW'(MAX_FRAME_BYTES)) begin
                m_tlast  <= 1'b1;
                m_tuser  <= 1'b1;
                if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
                state    <= S_DROP;
                low_prev <= 1'b0;
                held_v   <= 1'b0;
              end else begin
                byte_count <= byte_count + 1'b1;
              end
            end
          end
        end
        S_END: begin
          if (held_v) begin
            m_tdata  <= held;
            m_tvalid <= 1'b1;
            m_tlast  <= 1'b1;
            m_tuser  <= frame_err;
            if (frame_err) begin
              if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
            end else if (frame_cnt != '1) begin
              frame_cnt <= frame_cnt + 16'd1;
            end
          end
          held_v  <= 1'b0;
          running <= 1'b0;
          state   <= S_IDLE;
        end
        S_DROP: if (samp) begin
          if (!crsdv_r && low_prev) begin
            state   <= S_IDLE;
            running <= 1'b0;
          end else begin
            low_prev <= !crsdv_r;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
